// File: rtl/uint_mac_pkg.sv
// Shared types and default sizes for the unsigned multiply-accumulate block.
package uint_mac_pkg;

    localparam int ACC_W_DEF = 24;
    localparam int LEN_W_DEF = 8;
    localparam int PROD_W    = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/uint_sat_add.sv
// W-bit unsigned adder with carry-out; clamps to all-ones on carry when
// UINT_MAC_ACC_SAT_EN is defined, otherwise wraps modulo 2^W.
module uint_sat_add #(
    parameter int W = 24
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o,
    output logic         carry_o
);

    logic [W:0] full;

    assign full    = {1'b0, a_i} + {1'b0, b_i};
    assign carry_o = full[W];

`ifdef UINT_MAC_ACC_SAT_EN
    assign sum_o = full[W] ? {W{1'b1}} : full[W-1:0];
`else
    assign sum_o = full[W-1:0];
`endif

endmodule

// File: rtl/uint_mac_acc.sv
// Length-framed accumulator of 17-bit unsigned products with sticky overflow.
// Saturating accumulation is selected with the UINT_MAC_ACC_SAT_EN macro.
module uint_mac_acc
    import uint_mac_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] product_in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf,
    output logic              out_valid,
    input  logic              out_ready
);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W-1:0]   add_sum;
    logic               add_carry;

    uint_sat_add #(.W(ACC_W)) u_add (
        .a_i     (acc_q),
        .b_i     (ACC_W'(product_in)),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    if (len == '0) begin
                        state_d = DONE;
                    end else begin
                        cnt_d   = len;
                        state_d = ACCUM;
                    end
                end
            end
            ACCUM: begin
                // in_ready is high throughout ACCUM, so in_valid alone marks a beat
                if (in_valid) begin
                    acc_d = add_sum;
                    ovf_d = ovf_q | add_carry;
                    cnt_d = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign acc_out   = acc_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_uint_mac_acc.sv
// Directed bench for uint_mac_acc built with ACC_W=20 so overflow is reachable.
module tb_uint_mac_acc;

    localparam int ACC_W = 20;
    localparam int LEN_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic [16:0]      product_in;
    logic             in_valid;
    logic             in_ready;
    logic [ACC_W-1:0] acc_out;
    logic             ovf;
    logic             out_valid;
    logic             out_ready;

    int checks = 0;
    int errors = 0;

    uint_mac_acc #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .product_in (product_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .acc_out    (acc_out),
        .ovf        (ovf),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; product_in = '0;
        in_valid = 1'b0; out_ready = 1'b1;
        step(); step();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (acc_out !== 20'd0) begin errors++; $display("FAIL reset_acc got %0d want 0", acc_out); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b want 0", ovf); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        start = 1'b1; len = 8'd3;
        step();
        start = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready got %0b want 1", in_ready); end
        in_valid = 1'b1; product_in = 17'd65025;
        step(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b want 0", out_valid); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_out_valid got %0b want 1", out_valid); end
        checks++; if (acc_out !== 20'd195075) begin errors++; $display("FAIL basic_acc got %0d want 195075", acc_out); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %0b want 0", ovf); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_done_in_ready got %0b want 0", in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_release got %0b want 0", out_valid); end
    endtask

    task automatic test_stall_backpressure();
        out_ready = 1'b0;
        start = 1'b1; len = 8'd2;
        step();
        start = 1'b0;
        in_valid = 1'b1; product_in = 17'd100;
        step();
        in_valid = 1'b0; product_in = 17'd5000;
        step(); step();
        checks++; if (acc_out !== 20'd100) begin errors++; $display("FAIL stall_acc got %0d want 100", acc_out); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_in_ready got %0b want 1", in_ready); end
        in_valid = 1'b1; product_in = 17'd200;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %0b want 1", i, out_valid); end
            checks++; if (acc_out !== 20'd300) begin errors++; $display("FAIL hold_acc[%0d] got %0d want 300", i, acc_out); end
            step();
        end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_release got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_idle_ready got %0b want 0", in_ready); end
    endtask

    task automatic test_zero_len();
        out_ready = 1'b1;
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL zero_valid got %0b want 1", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_in_ready got %0b want 0", in_ready); end
        checks++; if (acc_out !== 20'd0) begin errors++; $display("FAIL zero_acc got %0d want 0", acc_out); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL zero_ovf got %0b want 0", ovf); end
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL zero_after_ready got %0b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL zero_after_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_overflow();
        logic [ACC_W-1:0] exp_acc;
`ifdef UINT_MAC_ACC_SAT_EN
        exp_acc = 20'd1048575;
`else
        exp_acc = 20'd56849;
`endif
        out_ready = 1'b1;
        start = 1'b1; len = 8'd17;
        step();
        start = 1'b0;
        in_valid = 1'b1; product_in = 17'd65025;
        for (int i = 0; i < 16; i++) step();
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got %0b want 0", ovf); end
        checks++; if (acc_out !== 20'd1040400) begin errors++; $display("FAIL ovf_pre_acc got %0d want 1040400", acc_out); end
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got %0b want 1", out_valid); end
        checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag got %0b want 1", ovf); end
        checks++; if (acc_out !== exp_acc) begin errors++; $display("FAIL ovf_acc got %0d want %0d", acc_out, exp_acc); end
        step();
        // a fresh start must clear the sticky flag
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        in_valid = 1'b1; product_in = 17'd5;
        step();
        in_valid = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %0b want 0", ovf); end
        checks++; if (acc_out !== 20'd5) begin errors++; $display("FAIL ovf_clear_acc got %0d want 5", acc_out); end
        step();
    endtask

    task automatic test_reset_mid_op();
        out_ready = 1'b1;
        start = 1'b1; len = 8'd4;
        step();
        start = 1'b0;
        in_valid = 1'b1; product_in = 17'd1000;
        step(); step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_in_ready got %0b want 0", in_ready); end
        checks++; if (acc_out !== 20'd0) begin errors++; $display("FAIL rstmid_acc got %0d want 0", acc_out); end
        start = 1'b1; len = 8'd1;
        step();
        start = 1'b0;
        in_valid = 1'b1; product_in = 17'd7;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid got %0b want 1", out_valid); end
        checks++; if (acc_out !== 20'd7) begin errors++; $display("FAIL rstmid_acc2 got %0d want 7", acc_out); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL rstmid_ovf got %0b want 0", ovf); end
        // reset while holding a result in DONE
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; out_ready = 1'b1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstdone_valid got %0b want 0", out_valid); end
        checks++; if (acc_out !== 20'd0) begin errors++; $display("FAIL rstdone_acc got %0d want 0", acc_out); end
    endtask

    task automatic test_ignored_start();
        out_ready = 1'b1;
        start = 1'b1; len = 8'd2;
        step();
        start = 1'b0;
        in_valid = 1'b1; product_in = 17'd10;
        step();
        in_valid = 1'b0;
        start = 1'b1; len = 8'd5;
        step();
        start = 1'b0;
        checks++; if (acc_out !== 20'd10) begin errors++; $display("FAIL ign_accum_acc got %0d want 10", acc_out); end
        in_valid = 1'b1; product_in = 17'd20;
        step();
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ign_len_done got %0b want 1", out_valid); end
        checks++; if (acc_out !== 20'd30) begin errors++; $display("FAIL ign_acc got %0d want 30", acc_out); end
        out_ready = 1'b0;
        start = 1'b1; len = 8'd0;
        step();
        start = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ign_done_valid got %0b want 1", out_valid); end
        checks++; if (acc_out !== 20'd30) begin errors++; $display("FAIL ign_done_acc got %0d want 30", acc_out); end
        out_ready = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ign_release got %0b want 0", out_valid); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ign_no_restart got %0b want 0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ign_idle_ready got %0b want 0", in_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_backpressure();
        test_zero_len();
        test_overflow();
        test_reset_mid_op();
        test_ignored_start();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uint_mac_acc.md
UINT_MAC_ACC -- requirements
Module: uint_mac_acc

Interface
REQ-001 SHALL have parameter: ACC_W, 24, accumulator/result width in bits (min 17).
REQ-002 SHALL have parameter: LEN_W, 8, width of beat-count field.
REQ-003 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port: start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-006 SHALL have port: len  input  LEN_W  number of products to accumulate; latched with start.
REQ-007 SHALL have port: product_in  input  17  unsigned product from upstream 8x8 multiplier.
REQ-008 SHALL have port: in_valid  input  1  product_in valid.
REQ-009 SHALL have port: in_ready  output  1  block accepts product_in this cycle.
REQ-010 SHALL have port: acc_out  output  ACC_W  final accumulated sum.
REQ-011 SHALL have port: ovf  output  1  sticky overflow flag for current result.
REQ-012 SHALL have port: out_valid  output  1  acc_out/ovf valid.
REQ-013 SHALL have port: out_ready  input  1  downstream accepts result.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-015 IDLE: in_ready=0, out_valid=0; start=1 with len>0 -> latch len, clear acc and ovf, go ACCUM next cycle.
REQ-016 IDLE: start=1 with len=0 -> clear acc and ovf, go DONE (result 0, ovf 0).
REQ-017 ACCUM: in_ready=1 combinationally; each beat with in_valid&&in_ready adds zero-extended product_in to acc and decrements remaining count.
REQ-018 ACCUM: in_valid=0 cycles SHALL stall without changing acc or count.
REQ-019 Acceptance of the final beat SHALL transition to DONE; out_valid asserted the cycle after that beat (latency 1).
REQ-020 DONE: in_ready=0, out_valid=1; acc_out and ovf SHALL remain stable while out_ready=0.
REQ-021 DONE with out_ready=1 -> IDLE next cycle; out_valid deasserts.
REQ-022 start SHALL be ignored in ACCUM and DONE.
REQ-023 ovf SHALL set when any addition's true sum exceeds 2^ACC_W-1 and stay set until the next accepted start.

Reset
REQ-024 rst=1 SHALL force IDLE, acc=0, count=0, ovf=0, in_ready=0, out_valid=0, acc_out=0 on the next edge.
REQ-025 Reset mid-ACCUM or mid-DONE SHALL discard the partial or pending result with no residual state.

Configuration
REQ-026 Macro UINT_MAC_ACC_SAT_EN defined: on overflow, acc SHALL clamp to 2^ACC_W-1 and hold there for remaining beats.
REQ-027 Macro UINT_MAC_ACC_SAT_EN undefined: acc SHALL wrap modulo 2^ACC_W; ovf behaviour unchanged.

Structure
REQ-028 Package uint_mac_pkg SHALL hold the state enum (IDLE/ACCUM/DONE) and the ACC_W/LEN_W default constants.
REQ-029 One sub-module uint_sat_add (ACC_W-bit adder returning sum and carry-out, clamping when saturation is enabled) SHALL be used for the accumulate step.

Verification
REQ-030 Basic: len=3, products 65025 x3 back-to-back, out_ready=1 -> acc_out=195075, ovf=0, out_valid 1 cycle after 3rd beat.
REQ-031 Stall/backpressure: len=2, products 100 and 200 with 2 idle cycles between, out_ready low 5 cycles -> acc_out=300 held stable 5 cycles, then IDLE.
REQ-032 Zero length: start with len=0 -> out_valid next cycle, acc_out=0, ovf=0, in_ready never asserted.
REQ-033 Overflow (ACC_W=20): len=17, each 65025 -> SAT_EN: acc_out=1048575, ovf=1; no SAT_EN: acc_out=56849, ovf=1.
REQ-034 Reset mid-op: rst after 2 of 4 beats, then new start len=1 product 7 -> acc_out=7, ovf=0.
REQ-035 Ignored start: start pulsed during ACCUM and DONE -> len, acc and result unaffected.
